// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: turns level/edge IRQ lines into a pending
// vector and tracks the claim/complete handshake for each source.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | nothing forwarded; waiting for a level-high line or a queued edge
// PENDING   | forwarded to the target arbiter, waiting for a claim
// INSERVICE | claimed by a hart, waiting for a complete
module plic_gateway #(
    parameter int SOURCE_COUNT   = 16,
    parameter int SOURCE_WIDTH   = 5,
    parameter int EDGE_CNT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SOURCE_COUNT-1:0] irq_src_i,
    input  logic [SOURCE_COUNT-1:0] irq_edge_i,
    input  logic                    claim_req_i,
    input  logic [SOURCE_WIDTH-1:0] claim_idx_i,
    input  logic                    complete_req_i,
    input  logic [SOURCE_WIDTH-1:0] complete_idx_i,
    output logic [SOURCE_COUNT-1:0] irq_pending_o,
    output logic [SOURCE_COUNT-1:0] irq_inservice_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PENDING   = 2'b01,
        ST_INSERVICE = 2'b10
    } state_t;

    localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX = {EDGE_CNT_WIDTH{1'b1}};

    state_t                    state_q [SOURCE_COUNT];
    state_t                    state_d [SOURCE_COUNT];
    logic [EDGE_CNT_WIDTH-1:0] cnt_q   [SOURCE_COUNT];
    logic [EDGE_CNT_WIDTH-1:0] cnt_d   [SOURCE_COUNT];
    logic [SOURCE_COUNT-1:0]   src_q;
    logic [SOURCE_COUNT-1:0]   rise;
    logic [SOURCE_COUNT-1:0]   fwd;
    logic [SOURCE_COUNT-1:0]   claim_hit;
    logic [SOURCE_COUNT-1:0]   complete_hit;

    assign rise = irq_src_i & ~src_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q <= '0;
            for (int i = 0; i < SOURCE_COUNT; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            src_q <= irq_src_i;
            for (int i = 0; i < SOURCE_COUNT; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // ID 0 and IDs above SOURCE_COUNT never match any source, so they are dropped here.
    always_comb begin
        for (int i = 0; i < SOURCE_COUNT; i++) begin
            claim_hit[i]    = claim_req_i    && (claim_idx_i    == SOURCE_WIDTH'(i + 1));
            complete_hit[i] = complete_req_i && (complete_idx_i == SOURCE_WIDTH'(i + 1));
        end
    end

    always_comb begin
        for (int i = 0; i < SOURCE_COUNT; i++) begin
            state_d[i] = state_q[i];
            fwd[i]     = 1'b0;
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (irq_edge_i[i]) begin
                        if ((cnt_q[i] != '0) || rise[i]) begin
                            state_d[i] = ST_PENDING;
                            fwd[i]     = 1'b1;
                        end
                    end else if (irq_src_i[i]) begin
                        state_d[i] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (claim_hit[i]) state_d[i] = ST_INSERVICE;
                end
                ST_INSERVICE: begin
                    if (complete_hit[i]) state_d[i] = ST_IDLE;
                end
                default: state_d[i] = ST_IDLE;
            endcase
            // A rise consumed by the same cycle's forward leaves the count unchanged.
            if (!irq_edge_i[i]) begin
                cnt_d[i] = '0;
            end else if (rise[i] && !fwd[i]) begin
                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!rise[i] && fwd[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SOURCE_COUNT; i++) begin
            irq_pending_o[i]   = (state_q[i] == ST_PENDING);
            irq_inservice_o[i] = (state_q[i] == ST_INSERVICE);
        end
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway; a second instance with a 2-bit edge counter
// shares the stimulus so saturation can be compared against the wide counter.
module tb_plic_gateway;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq_src;
    logic [15:0] irq_edge;
    logic        claim_req;
    logic [4:0]  claim_idx;
    logic        complete_req;
    logic [4:0]  complete_idx;
    logic [15:0] pend_a, insv_a, pend_b, insv_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    plic_gateway #(.SOURCE_COUNT(16), .SOURCE_WIDTH(5), .EDGE_CNT_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .irq_src_i(irq_src), .irq_edge_i(irq_edge),
        .claim_req_i(claim_req), .claim_idx_i(claim_idx),
        .complete_req_i(complete_req), .complete_idx_i(complete_idx),
        .irq_pending_o(pend_a), .irq_inservice_o(insv_a)
    );

    plic_gateway #(.SOURCE_COUNT(16), .SOURCE_WIDTH(5), .EDGE_CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .irq_src_i(irq_src), .irq_edge_i(irq_edge),
        .claim_req_i(claim_req), .claim_idx_i(claim_idx),
        .complete_req_i(complete_req), .complete_idx_i(complete_idx),
        .irq_pending_o(pend_b), .irq_inservice_o(insv_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_claim(input logic [4:0] idx);
        claim_req = 1'b1;
        claim_idx = idx;
        tick();
        claim_req = 1'b0;
        claim_idx = '0;
    endtask

    task automatic do_complete(input logic [4:0] idx);
        complete_req = 1'b1;
        complete_idx = idx;
        tick();
        complete_req = 1'b0;
        complete_idx = '0;
    endtask

    task automatic pulse_src0(input int n);
        for (int k = 0; k < n; k++) begin
            irq_src[0] = 1'b1;
            tick();
            irq_src[0] = 1'b0;
            tick();
        end
    endtask

    // Fixed number of complete/claim rounds on source 1, counting re-pends per instance.
    task automatic count_repends(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int r = 0; r < 8; r++) begin
            do_complete(5'd1);
            tick();
            if (pend_a[0]) na++;
            if (pend_b[0]) nb++;
            do_claim(5'd1);
        end
    endtask

    int na, nb;

    initial begin
        rst          = 1'b1;
        irq_src      = '0;
        irq_edge     = '0;
        claim_req    = 1'b0;
        claim_idx    = '0;
        complete_req = 1'b0;
        complete_idx = '0;
        tick();
        check_val("rst_pend",   32'(pend_a), 32'h0);
        check_val("rst_insv",   32'(insv_a), 32'h0);
        check_val("rst_pend_b", 32'(pend_b), 32'h0);
        rst = 1'b0;
        tick();

        // level basic on source 3
        irq_src[2] = 1'b1;
        check_val("lvl_before", 32'(pend_a), 32'h0);
        tick();
        check_val("lvl_pend", 32'(pend_a), 32'h4);
        do_claim(5'd3);
        check_val("lvl_claim_pend", 32'(pend_a), 32'h0);
        check_val("lvl_claim_insv", 32'(insv_a), 32'h4);
        do_complete(5'd3);
        check_val("lvl_cmpl_insv", 32'(insv_a), 32'h0);
        check_val("lvl_cmpl_pend", 32'(pend_a), 32'h0);
        tick();
        check_val("lvl_repend", 32'(pend_a), 32'h4);
        do_claim(5'd3);
        irq_src[2] = 1'b0;
        do_complete(5'd3);
        tick();
        check_val("lvl_quiet_pend", 32'(pend_a), 32'h0);
        check_val("lvl_quiet_insv", 32'(insv_a), 32'h0);

        // edge burst on source 1: three pulses while in service
        irq_edge[0] = 1'b1;
        pulse_src0(1);
        check_val("edge_first_pend", 32'(pend_a), 32'h1);
        do_claim(5'd1);
        check_val("edge_first_insv", 32'(insv_a), 32'h1);
        pulse_src0(3);
        check_val("edge_held_insv", 32'(insv_a), 32'h1);
        count_repends(na, nb);
        check_val("burst_repends",   32'(na), 32'd3);
        check_val("burst_repends_b", 32'(nb), 32'd3);
        check_val("burst_idle_pend", 32'(pend_a), 32'h0);
        check_val("burst_idle_insv", 32'(insv_a), 32'h0);

        // saturation: five pulses, 4-bit counter keeps all, 2-bit counter stops at 3
        pulse_src0(1);
        do_claim(5'd1);
        check_val("sat_insv_b", 32'(insv_b), 32'h1);
        pulse_src0(5);
        count_repends(na, nb);
        check_val("sat_repends_wide", 32'(na), 32'd5);
        check_val("sat_repends_b",    32'(nb), 32'd3);
        irq_edge[0] = 1'b0;

        // illegal strobes leave source 4 pending
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        tick();
        check_val("ill_hold_pend", 32'(pend_a), 32'h8);
        do_claim(5'd0);
        check_val("ill_id0_pend", 32'(pend_a), 32'h8);
        check_val("ill_id0_insv", 32'(insv_a), 32'h0);
        do_claim(5'd17);
        check_val("ill_id17_pend", 32'(pend_a), 32'h8);
        check_val("ill_id17_insv", 32'(insv_a), 32'h0);
        do_claim(5'd6);
        check_val("ill_idle_pend", 32'(pend_a), 32'h8);
        check_val("ill_idle_insv", 32'(insv_a), 32'h0);
        do_complete(5'd4);
        check_val("ill_cmpl_pend", 32'(pend_a), 32'h8);
        check_val("ill_cmpl_insv", 32'(insv_a), 32'h0);

        // same-ID claim+complete: only the legal transition applies
        claim_req = 1'b1; claim_idx = 5'd4; complete_req = 1'b1; complete_idx = 5'd4;
        tick();
        check_val("same_p2i_pend", 32'(pend_a), 32'h0);
        check_val("same_p2i_insv", 32'(insv_a), 32'h8);
        tick();
        check_val("same_i2d_insv", 32'(insv_a), 32'h0);
        check_val("same_i2d_pend", 32'(pend_a), 32'h0);
        claim_req = 1'b0; complete_req = 1'b0; claim_idx = '0; complete_idx = '0;

        // concurrent claim 2 / complete 5
        irq_src[4] = 1'b1;
        tick();
        do_claim(5'd5);
        irq_src[4] = 1'b0;
        irq_src[1] = 1'b1;
        tick();
        irq_src[1] = 1'b0;
        check_val("conc_setup_pend", 32'(pend_a), 32'h2);
        check_val("conc_setup_insv", 32'(insv_a), 32'h10);
        claim_req = 1'b1; claim_idx = 5'd2; complete_req = 1'b1; complete_idx = 5'd5;
        tick();
        claim_req = 1'b0; complete_req = 1'b0; claim_idx = '0; complete_idx = '0;
        check_val("conc_pend", 32'(pend_a), 32'h0);
        check_val("conc_insv", 32'(insv_a), 32'h2);
        do_complete(5'd2);
        check_val("conc_done", 32'(insv_a), 32'h0);

        // reset mid-service with mixed states and a queued edge count
        irq_edge[0] = 1'b1;
        irq_src[2]  = 1'b1;
        irq_src[6]  = 1'b1;
        irq_src[9]  = 1'b1;
        pulse_src0(1);
        do_claim(5'd7);
        pulse_src0(2);
        irq_src[6] = 1'b0;
        irq_src[9] = 1'b0;
        check_val("mix_pend", 32'(pend_a), 32'h205);
        check_val("mix_insv", 32'(insv_a), 32'h40);
        rst = 1'b1;
        claim_req = 1'b1; claim_idx = 5'd3;
        tick();
        claim_req = 1'b0; claim_idx = '0;
        check_val("midrst_pend", 32'(pend_a), 32'h0);
        check_val("midrst_insv", 32'(insv_a), 32'h0);
        rst = 1'b0;
        tick();
        check_val("postrst_pend", 32'(pend_a), 32'h4);
        check_val("postrst_insv", 32'(insv_a), 32'h0);
        tick();
        check_val("postrst_pend2", 32'(pend_a), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
# plic_gateway

Per-source interrupt gateway for the PLIC. It converts raw level- or edge-triggered device interrupt lines into the pending vector consumed by the PLIC target arbiter. It owns the claim/complete handshake from the hart side: a claim clears a source's pending bit and holds the source in service, and a complete re-arms it. It sits between the synchronized device IRQ lines and the `plic_target` instances, alongside the PLIC register file that generates claim/complete strobes.

## Interface
- `SOURCE_COUNT`, default 16: number of interrupt sources; source IDs are 1..SOURCE_COUNT, and ID 0 means "none".
- `SOURCE_WIDTH`, default 5: width of source ID fields; must satisfy 2^SOURCE_WIDTH > SOURCE_COUNT.
- `EDGE_CNT_WIDTH`, default 4: width of each source's outstanding-edge counter; the counter saturates at 2^EDGE_CNT_WIDTH-1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `irq_src_i` in SOURCE_COUNT: raw interrupt lines, already synchronized to `clk`; bit i is source ID i+1.
- `irq_edge_i` in SOURCE_COUNT: per-source trigger mode; 1 = rising-edge, 0 = level-high.
- `claim_req_i` in 1: single-cycle claim strobe.
- `claim_idx_i` in SOURCE_WIDTH: ID being claimed.
- `complete_req_i` in 1: single-cycle complete strobe.
- `complete_idx_i` in SOURCE_WIDTH: ID being completed.
- `irq_pending_o` out SOURCE_COUNT: pending vector to the target arbiter, registered.
- `irq_inservice_o` out SOURCE_COUNT: in-service vector for status and debug, registered.

## Operation
- Each source has a 3-state FSM: IDLE, PENDING, INSERVICE. Encoding is free.
  - `irq_pending_o[i]` is 1 only in PENDING.
  - `irq_inservice_o[i]` is 1 only in INSERVICE.
- Edge detection: a per-source register `src_q` holds the previous `irq_src_i`. `rise[i] = irq_src_i[i] & ~src_q[i]`.
- Level mode (`irq_edge_i[i]=0`):
  - IDLE and `irq_src_i[i]=1` -> PENDING.
  - PENDING holds even if the line drops; it is not retracted.
  - In INSERVICE the line is ignored.
  - The edge counter is held at 0.
- Edge mode (`irq_edge_i[i]=1`):
  - `fwd = (state==IDLE) & (cnt!=0 | rise)`; `fwd` moves the source to PENDING.
  - `cnt_next = cnt + rise - fwd`, saturating at max. At max, an unmatched `rise` is dropped.
  - Edges arriving in PENDING or INSERVICE are counted, not lost.
- Claim (`claim_req_i=1`, `idx` in 1..SOURCE_COUNT, source `idx` in PENDING) -> INSERVICE.
  - Ignored for `idx` 0, out-of-range `idx`, or a source not in PENDING.
- Complete (`complete_req_i=1`, valid `idx`, source in INSERVICE) -> IDLE.
  - Ignored otherwise.
  - From IDLE, a still-high level line or a nonzero edge count re-pends on the next cycle.
- Simultaneous events:
  - Claim and complete of different IDs in one cycle: both applied.
  - Claim and complete of the same ID: only the transition legal from the current state applies, since a source cannot be both PENDING and INSERVICE.
  - Mode change takes effect on the next edge. Switching to level clears the counter; the FSM state is kept.

## Timing
- Reset: all FSMs IDLE, all counters 0, `src_q` 0. `irq_pending_o` and `irq_inservice_o` are all 0 in the cycle after `rst` is sampled high.
- `src_q` resets to 0, so a line already high when reset releases counts as a rising edge in edge mode.
- Latency from source to pending is 1 cycle for both modes: the condition is sampled at edge k, and `irq_pending_o` is high after edge k.
  - Through the target's register, the arbiter's request rises 2 cycles after the source.
- Claim: strobe sampled at edge k -> pending low and in-service high after edge k.
- Complete: strobe sampled at edge k -> in-service low after edge k. Re-pend is visible no earlier than after edge k+1.
- `rst` asserted mid-operation forces all state to reset values at the next edge, regardless of strobes.

## Test plan
- Level basic: source 3 level, `irq_src_i[2]=1` at cycle 5 -> `irq_pending_o[2]=1` from cycle 6. Claim ID 3 at cycle 8 -> pending 0 and inservice 1 from cycle 9. Line still high, complete at cycle 12 -> inservice 0 at 13, pending 1 at 14.
- Edge burst: source 1 edge mode, three single-cycle pulses while INSERVICE -> cnt=3. Each complete/claim round re-pends once; exactly 3 more pend events occur, then the source stays IDLE.
- Counter saturation: EDGE_CNT_WIDTH=2, 5 pulses while INSERVICE -> cnt=3. Exactly 3 later pend events.
- Illegal strobes: claim ID 0, claim ID 17, claim of an IDLE source, complete of a PENDING source -> no state change on any output.
- Concurrent: source 2 PENDING and source 5 INSERVICE; claim 2 and complete 5 in the same cycle -> next cycle inservice[1]=1, pending[1]=0, inservice[4]=0.
- Reset mid-service: 4 sources in mixed states, `rst` high one cycle -> all outputs 0 next cycle. A level line held high re-pends one cycle after `rst` drops.
